cam_lookup: RTL and testbench

Fully associative key/data store with a pipelined search port, the read side of the team's 64-entry CAM storage. A fill port installs or updates entries, and a valid/ready search port returns hit, data and entry index two cycles after acceptance. It is intended for translation and victim lookups beside the pipelined datapath, where the requester needs a registered, stallable result.

---
 rtl/cam_pkg.sv | 19 +
 rtl/cam_prio_enc.sv | 26 ++
 rtl/cam_lookup.sv | 152 +++++++++++++++
 tb/tb_cam_lookup.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared types and helpers for the CAM lookup block.
//   CAM_W       - key/data width that the entry storage type is built for
//   cam_entry_t - one CAM entry: valid bit, key, data
//   idx_w()     - index width for a given entry count
package cam_pkg;

    localparam int unsigned CAM_W = 32;

    typedef struct packed {
        logic             valid;
        logic [CAM_W-1:0] key;
        logic [CAM_W-1:0] data;
    } cam_entry_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// cam_prio_enc: multi-hot to index encoder, lowest set bit wins.
//   vec_i - request vector (any number of bits set)
//   idx_o - index of the lowest set bit, 0 when none set
//   any_o - at least one bit set
module cam_prio_enc
    import cam_pkg::*;
#(
    parameter int unsigned N  = 64,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan from the top down so the lowest set bit is the last write.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IW'(i);
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/cam_lookup.sv
// cam_lookup: fully associative key/data store with a two-stage,
// valid/ready search pipeline.
//   clk, rst          - clock, synchronous active-high reset
//   flush             - clear all valid bits, victim pointer back to 0
//   fill/fill_key/
//   fill_data         - install or update an entry (one-cycle strobe)
//   req_valid/req_key/
//   req_ready         - search request handshake
//   resp_valid/
//   resp_ready        - search response handshake
//   resp_hit/resp_data/
//   resp_idx          - search result (data and idx are 0 on a miss)
module cam_lookup
    import cam_pkg::*;
#(
    parameter int unsigned width   = CAM_W,
    parameter int unsigned entries = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        fill,
    input  logic [width-1:0]            fill_key,
    input  logic [width-1:0]            fill_data,
    input  logic                        req_valid,
    input  logic [width-1:0]            req_key,
    output logic                        req_ready,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic                        resp_hit,
    output logic [width-1:0]            resp_data,
    output logic [idx_w(entries)-1:0]   resp_idx
);

    localparam int unsigned IW = idx_w(entries);

    // Entry storage is built from the package entry type.
    if (width != CAM_W) begin : g_bad_width
        $error("cam_lookup: width must equal cam_pkg::CAM_W");
    end

    cam_entry_t        ent_q [entries];
    cam_entry_t        ent_d [entries];
    logic [IW-1:0]     victim_q, victim_d;

    logic [entries-1:0] fill_match, free_vec, srch_match;
    logic [width-1:0]   srch_data;
    logic [IW-1:0]      free_idx;
    logic               free_any;

    // Parallel compares against the current (pre-update) array contents,
    // so a search in the same cycle as a fill/flush sees the old state.
    always_comb begin
        srch_data = '0;
        for (int i = 0; i < entries; i++) begin
            fill_match[i] = ent_q[i].valid && (ent_q[i].key == fill_key);
            srch_match[i] = ent_q[i].valid && (ent_q[i].key == req_key);
            free_vec[i]   = !ent_q[i].valid;
            srch_data     = srch_data | (ent_q[i].data & {width{srch_match[i]}});
        end
    end

    cam_prio_enc #(.N(entries), .IW(IW)) u_free_enc (
        .vec_i (free_vec),
        .idx_o (free_idx),
        .any_o (free_any)
    );

    // Fill/flush next state. Keys are unique, so at most one fill_match bit.
    always_comb begin
        ent_d    = ent_q;
        victim_d = victim_q;
        if (flush) begin
            for (int i = 0; i < entries; i++) ent_d[i].valid = 1'b0;
            victim_d = '0;
        end else if (fill) begin
            if (|fill_match) begin
                for (int i = 0; i < entries; i++) begin
                    if (fill_match[i]) ent_d[i].data = fill_data;
                end
            end else if (free_any) begin
                ent_d[free_idx] = '{valid: 1'b1, key: fill_key, data: fill_data};
            end else begin
                ent_d[victim_q] = '{valid: 1'b1, key: fill_key, data: fill_data};
                victim_d        = victim_q + IW'(1);
            end
        end
    end

    // Key/data are not reset; only the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < entries; i++) ent_q[i].valid <= 1'b0;
            victim_q <= '0;
        end else begin
            ent_q    <= ent_d;
            victim_q <= victim_d;
        end
    end

    // Search pipeline
    logic                s1_valid_q;
    logic [entries-1:0]  s1_match_q;
    logic [width-1:0]    s1_data_q;
    logic                resp_valid_q, resp_hit_q;
    logic [width-1:0]    resp_data_q;
    logic [IW-1:0]       resp_idx_q, s2_idx;
    logic                s2_any, s2_load, accept;

    assign s2_load   = !resp_valid_q || resp_ready;
    assign req_ready = !s1_valid_q || s2_load;
    assign accept    = req_valid && req_ready;

    cam_prio_enc #(.N(entries), .IW(IW)) u_idx_enc (
        .vec_i (s1_match_q),
        .idx_o (s2_idx),
        .any_o (s2_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_match_q   <= '0;
            s1_data_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_data_q  <= '0;
            resp_idx_q   <= '0;
        end else begin
            // S1 is free to take a new request whenever req_ready is high.
            if (req_ready) s1_valid_q <= req_valid;
            if (accept) begin
                s1_match_q <= srch_match;
                s1_data_q  <= srch_data;
            end
            if (s2_load) begin
                resp_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    resp_hit_q  <= s2_any;
                    resp_data_q <= s1_data_q;
                    resp_idx_q  <= s2_idx;
                end
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_data  = resp_data_q;
    assign resp_idx   = resp_idx_q;

endmodule

// File: tb/tb_cam_lookup.sv
module tb_cam_lookup;

    logic        clk;
    logic        rst, flush, fill, req_valid, resp_ready;
    logic [31:0] fill_key, fill_data, req_key;
    logic        req_ready, resp_valid, resp_hit;
    logic [31:0] resp_data;
    logic [5:0]  resp_idx;

    int tests_run    = 0;
    int tests_failed = 0;

    cam_lookup #(.width(32), .entries(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fill       (fill),
        .fill_key   (fill_key),
        .fill_data  (fill_data),
        .req_valid  (req_valid),
        .req_key    (req_key),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hit   (resp_hit),
        .resp_data  (resp_data),
        .resp_idx   (resp_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; fill = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_fill(input logic [31:0] k, input logic [31:0] d);
        fill = 1'b1; fill_key = k; fill_data = d;
        tick();
        fill = 1'b0;
    endtask

    // Issue one search and wait (bounded) for its response; lat counts
    // cycles from the acceptance cycle to the cycle resp_valid is seen.
    task automatic do_search(input logic [31:0] k, output logic hit,
                             output logic [31:0] data, output logic [5:0] idx,
                             output int lat);
        req_valid = 1'b1; req_key = k;
        #1;
        for (int n = 0; !req_ready && n < 20; n++) tick();
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        hit = resp_hit; data = resp_data; idx = resp_idx;
        tick();
    endtask

    task automatic test_reset();
        logic h; logic [31:0] d; logic [5:0] ix; int lat; logic seen;
        do_reset();
        tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset.resp_valid got %0b exp 0", resp_valid); end
        tests_run++; if (resp_hit !== 1'b0) begin tests_failed++; $display("FAIL reset.resp_hit got %0b exp 0", resp_hit); end
        tests_run++; if (resp_data !== 32'h0) begin tests_failed++; $display("FAIL reset.resp_data got %h exp 0", resp_data); end
        tests_run++; if (resp_idx !== 6'd0) begin tests_failed++; $display("FAIL reset.resp_idx got %0d exp 0", resp_idx); end
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset.req_ready got %0b exp 1", req_ready); end
        // Mid-operation reset discards the in-flight search; fill during reset is ignored.
        do_fill(32'h5, 32'h6);
        req_valid = 1'b1; req_key = 32'h5;
        tick();
        req_valid = 1'b0; rst = 1'b1;
        fill = 1'b1; fill_key = 32'h6; fill_data = 32'h7;
        tick();
        rst = 1'b0; fill = 1'b0;
        seen = 1'b0;
        repeat (3) begin if (resp_valid) seen = 1'b1; tick(); end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL reset.inflight_dropped got %0b exp 0", seen); end
        do_search(32'h5, h, d, ix, lat);
        tests_run++; if (h !== 1'b0) begin tests_failed++; $display("FAIL reset.valid_cleared got %0b exp 0", h); end
        do_search(32'h6, h, d, ix, lat);
        tests_run++; if (h !== 1'b0) begin tests_failed++; $display("FAIL reset.fill_ignored got %0b exp 0", h); end
    endtask

    task automatic test_miss_hit();
        logic h; logic [31:0] d; logic [5:0] ix; int lat;
        do_reset();
        do_search(32'hDEAD_BEEF, h, d, ix, lat);
        tests_run++; if ({h, d, ix} !== {1'b0, 32'h0, 6'd0}) begin tests_failed++; $display("FAIL miss_hit.miss got hit=%0b data=%h idx=%0d exp 0/0/0", h, d, ix); end
        do_fill(32'hDEAD_BEEF, 32'h1234_5678);
        do_search(32'hDEAD_BEEF, h, d, ix, lat);
        tests_run++; if ({h, d, ix} !== {1'b1, 32'h1234_5678, 6'd0}) begin tests_failed++; $display("FAIL miss_hit.hit got hit=%0b data=%h idx=%0d exp 1/12345678/0", h, d, ix); end
        tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL miss_hit.latency got %0d exp 2", lat); end
    endtask

    task automatic test_update();
        logic h; logic [31:0] d; logic [5:0] ix; int lat;
        do_reset();
        do_fill(32'h10, 32'hA);
        do_fill(32'h10, 32'hB);
        do_search(32'h10, h, d, ix, lat);
        tests_run++; if ({h, d, ix} !== {1'b1, 32'hB, 6'd0}) begin tests_failed++; $display("FAIL update.in_place got hit=%0b data=%h idx=%0d exp 1/b/0", h, d, ix); end
        do_fill(32'h20, 32'hC);
        do_search(32'h20, h, d, ix, lat);
        tests_run++; if ({h, d, ix} !== {1'b1, 32'hC, 6'd1}) begin tests_failed++; $display("FAIL update.next_key got hit=%0b data=%h idx=%0d exp 1/c/1", h, d, ix); end
    endtask

    task automatic test_evict();
        logic h; logic [31:0] d; logic [5:0] ix; int lat;
        do_reset();
        for (int i = 0; i < 64; i++) do_fill(32'h1000 + i, 32'hA000 + i);
        do_search(32'h103F, h, d, ix, lat);
        tests_run++; if ({h, d, ix} !== {1'b1, 32'hA03F, 6'd63}) begin tests_failed++; $display("FAIL evict.last got hit=%0b data=%h idx=%0d exp 1/a03f/63", h, d, ix); end
        do_fill(32'h2000, 32'hAA);
        do_fill(32'h2001, 32'hBB);
        do_search(32'h1000, h, d, ix, lat);
        tests_run++; if ({h, d, ix} !== {1'b0, 32'h0, 6'd0}) begin tests_failed++; $display("FAIL evict.first_gone got hit=%0b data=%h idx=%0d exp 0/0/0", h, d, ix); end
        do_search(32'h2000, h, d, ix, lat);
        tests_run++; if ({h, d, ix} !== {1'b1, 32'hAA, 6'd0}) begin tests_failed++; $display("FAIL evict.k65 got hit=%0b data=%h idx=%0d exp 1/aa/0", h, d, ix); end
        do_search(32'h2001, h, d, ix, lat);
        tests_run++; if ({h, d, ix} !== {1'b1, 32'hBB, 6'd1}) begin tests_failed++; $display("FAIL evict.k66 got hit=%0b data=%h idx=%0d exp 1/bb/1", h, d, ix); end
        do_search(32'h1002, h, d, ix, lat);
        tests_run++; if ({h, d, ix} !== {1'b1, 32'hA002, 6'd2}) begin tests_failed++; $display("FAIL evict.k3_kept got hit=%0b data=%h idx=%0d exp 1/a002/2", h, d, ix); end
        // Flush returns the victim pointer to 0.
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 64; i++) do_fill(32'h3000 + i, 32'hB000 + i);
        do_fill(32'h4000, 32'hCC);
        do_search(32'h4000, h, d, ix, lat);
        tests_run++; if ({h, d, ix} !== {1'b1, 32'hCC, 6'd0}) begin tests_failed++; $display("FAIL evict.victim_after_flush got hit=%0b data=%h idx=%0d exp 1/cc/0", h, d, ix); end
    endtask

    task automatic test_same_cycle();
        logic h; logic [31:0] d; logic [5:0] ix; int lat;
        do_reset();
        fill = 1'b1; fill_key = 32'h55; fill_data = 32'h77;
        req_valid = 1'b1; req_key = 32'h55;
        tick();
        fill = 1'b0; req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin tick(); lat++; end
        tests_run++; if ({resp_valid, resp_hit} !== 2'b10) begin tests_failed++; $display("FAIL same_cycle.miss got valid=%0b hit=%0b exp 1/0", resp_valid, resp_hit); end
        tick();
        do_search(32'h55, h, d, ix, lat);
        tests_run++; if ({h, d, ix} !== {1'b1, 32'h77, 6'd0}) begin tests_failed++; $display("FAIL same_cycle.next_hit got hit=%0b data=%h idx=%0d exp 1/77/0", h, d, ix); end
    endtask

    task automatic test_flush();
        logic h; logic [31:0] d; logic [5:0] ix; int lat;
        do_reset();
        do_fill(32'h33, 32'h99);
        // Flush in the acceptance cycle; the search still sees the old array.
        req_valid = 1'b1; req_key = 32'h33; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin tick(); lat++; end
        tests_run++; if ({resp_valid, resp_hit, resp_data} !== {2'b11, 32'h99}) begin tests_failed++; $display("FAIL flush.inflight got valid=%0b hit=%0b data=%h exp 1/1/99", resp_valid, resp_hit, resp_data); end
        tick();
        do_search(32'h33, h, d, ix, lat);
        tests_run++; if (h !== 1'b0) begin tests_failed++; $display("FAIL flush.later_miss got %0b exp 0", h); end
        flush = 1'b1; fill = 1'b1; fill_key = 32'h44; fill_data = 32'h1;
        tick();
        flush = 1'b0; fill = 1'b0;
        do_fill(32'h45, 32'h2);
        do_search(32'h45, h, d, ix, lat);
        tests_run++; if ({h, d, ix} !== {1'b1, 32'h2, 6'd0}) begin tests_failed++; $display("FAIL flush.next_fill_idx0 got hit=%0b data=%h idx=%0d exp 1/2/0", h, d, ix); end
        do_search(32'h44, h, d, ix, lat);
        tests_run++; if (h !== 1'b0) begin tests_failed++; $display("FAIL flush.fill_dropped got %0b exp 0", h); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] keys [5];
        logic        exp_h [5];
        logic [31:0] exp_d [5];
        logic [5:0]  exp_i [5];
        logic        got_h [5];
        logic [31:0] got_d [5];
        logic [5:0]  got_i [5];
        int k, nr, stall_k;
        logic rr, stall_rr, snap_v, snap_ok, dup;
        logic [38:0] snap;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_fill(32'h100 + i, 32'hD0 + i);
            keys[i] = 32'h100 + i; exp_h[i] = 1'b1; exp_d[i] = 32'hD0 + i; exp_i[i] = 6'(i);
        end
        keys[4] = 32'h7777; exp_h[4] = 1'b0; exp_d[4] = 32'h0; exp_i[4] = 6'd0;
        k = 0; nr = 0; snap_v = 1'b0; snap_ok = 1'b1; stall_k = -1; stall_rr = 1'bx; snap = '0;
        for (int cyc = 0; cyc < 40 && nr < 5; cyc++) begin
            resp_ready = (cyc >= 5);
            req_valid  = (k < 5);
            req_key    = (k < 5) ? keys[k] : 32'h0;
            #1;
            rr = req_ready;
            if (cyc == 4) begin stall_rr = req_ready; stall_k = k; end
            if (resp_valid && !resp_ready) begin
                if (!snap_v) begin snap_v = 1'b1; snap = {resp_hit, resp_data, resp_idx}; end
                else if ({resp_hit, resp_data, resp_idx} !== snap) snap_ok = 1'b0;
            end
            if (resp_valid && resp_ready) begin
                got_h[nr] = resp_hit; got_d[nr] = resp_data; got_i[nr] = resp_idx; nr++;
            end
            tick();
            if (rr && k < 5) k++;
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        dup = 1'b0;
        repeat (3) begin if (resp_valid) dup = 1'b1; tick(); end
        tests_run++; if (stall_rr !== 1'b0) begin tests_failed++; $display("FAIL b2b.ready_drop got %0b exp 0", stall_rr); end
        tests_run++; if (stall_k !== 2) begin tests_failed++; $display("FAIL b2b.accepted_in_stall got %0d exp 2", stall_k); end
        tests_run++; if ({snap_v, snap_ok, snap} !== {2'b11, 1'b1, 32'hD0, 6'd0}) begin tests_failed++; $display("FAIL b2b.hold_stable got seen=%0b stable=%0b resp=%h exp 1/1/%h", snap_v, snap_ok, snap, {1'b1, 32'hD0, 6'd0}); end
        tests_run++; if (nr !== 5) begin tests_failed++; $display("FAIL b2b.count got %0d exp 5", nr); end
        tests_run++; if (dup !== 1'b0) begin tests_failed++; $display("FAIL b2b.no_dup got %0b exp 0", dup); end
        for (int i = 0; i < nr; i++) begin
            tests_run++;
            if ({got_h[i], got_d[i], got_i[i]} !== {exp_h[i], exp_d[i], exp_i[i]}) begin
                tests_failed++;
                $display("FAIL b2b.resp%0d got hit=%0b data=%h idx=%0d exp %0b/%h/%0d", i, got_h[i], got_d[i], got_i[i], exp_h[i], exp_d[i], exp_i[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; fill = 1'b0; fill_key = '0; fill_data = '0;
        req_valid = 1'b0; req_key = '0; resp_ready = 1'b1;
        test_reset();
        test_miss_hit();
        test_update();
        test_evict();
        test_same_cycle();
        test_flush();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
